// File: rtl/byte_serial_accumulator_if.sv
// Pin-side bundle for byte_serial_accumulator: operand/command inputs and readback outputs.
// master = host driving commands, slave = the accumulator.
interface byte_serial_accumulator_if #(
  parameter int unsigned NBYTES = 4
);
  localparam int unsigned SELW = $clog2(NBYTES);

  logic [7:0]      din;
  logic            din_valid;
  logic            start;
  logic            clear;
  logic            sub;
  logic [SELW-1:0] rd_sel;
  logic [7:0]      dout;
  logic            busy;
  logic            done;
  logic            carry_out;

  modport master (
    output din, din_valid, start, clear, sub, rd_sel,
    input  dout, busy, done, carry_out
  );

  modport slave (
    input  din, din_valid, start, clear, sub, rd_sel,
    output dout, busy, done, carry_out
  );
endinterface

// File: rtl/byte_serial_accumulator.sv
// Byte-serial NBYTES-wide accumulator sharing one 8-bit adder, LSB-first with a carry flop.
// Define BYTE_ACC_SUB_EN to enable subtraction (inverted operand, initial carry of 1).
module byte_serial_accumulator #(
  parameter int unsigned NBYTES = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  byte_serial_accumulator_if.slave bus
);
  localparam int unsigned SELW = $clog2(NBYTES);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic                   state_q, state_d;
  logic [NBYTES-1:0][7:0] acc_q, acc_d;
  logic [NBYTES-1:0][7:0] op_q, op_d;
  logic [SELW-1:0]        idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic                   carry_out_q, carry_out_d;
  logic                   done_q, done_d;

  logic [7:0] acc_byte;
  logic [7:0] op_byte;
  logic [7:0] addend;
  logic [8:0] sum;
  logic       last_byte;
  logic       start_carry;
  logic [7:0] dout_w;

`ifdef BYTE_ACC_SUB_EN
  logic sub_q, sub_d;

  assign addend      = sub_q ? ~op_byte : op_byte;
  assign start_carry = bus.sub;
`else
  // sub has no effect in the add-only build.
  logic unused_sub;

  assign unused_sub  = bus.sub;
  assign addend      = op_byte;
  assign start_carry = 1'b0;
`endif

  assign acc_byte  = acc_q[idx_q];
  assign op_byte   = op_q[idx_q];
  assign sum       = {1'b0, acc_byte} + {1'b0, addend} + {8'h00, carry_q};
  assign last_byte = (idx_q == SELW'(NBYTES - 1));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    done_d      = 1'b0;
`ifdef BYTE_ACC_SUB_EN
    sub_d       = sub_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.clear) begin
          acc_d       = '0;
          op_d        = '0;
          carry_out_d = 1'b0;
        end else if (bus.start) begin
          state_d = StRun;
          idx_d   = '0;
          carry_d = start_carry;
`ifdef BYTE_ACC_SUB_EN
          sub_d   = bus.sub;
`endif
        end else if (bus.din_valid) begin
          // New bytes enter at the top so the first byte written ends up as the LSB.
          op_d = {bus.din, op_q[NBYTES-1:1]};
        end
      end
      StRun: begin
        acc_d[idx_q] = sum[7:0];
        carry_d      = sum[8];
        idx_d        = idx_q + SELW'(1);
        if (last_byte) begin
          carry_out_d = sum[8];
          state_d     = StIdle;
          done_d      = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      done_q      <= done_d;
    end
  end

`ifdef BYTE_ACC_SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end
`endif

  // Readback is live, so partially updated bytes are visible while running.
  always_comb begin
    dout_w = 8'h00;
    if (32'(bus.rd_sel) < NBYTES) begin
      dout_w = acc_q[bus.rd_sel];
    end
  end

  assign bus.dout      = dout_w;
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = done_q;
  assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_byte_serial_accumulator.sv
// Scoreboard bench for byte_serial_accumulator: random and directed operations against an
// arithmetic model; a monitor checks every done pulse and idle readback request.
module tb_byte_serial_accumulator;
  localparam int NB   = 4;
  localparam int W    = 8 * NB;
  localparam int SELW = $clog2(NB);

  typedef struct packed {
    logic [W-1:0] acc;
    logic         co;
  } exp_t;

  logic clk;
  logic rst_n;

  byte_serial_accumulator_if #(.NBYTES(NB)) bus ();

  byte_serial_accumulator #(.NBYTES(NB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  exp_t         exp_q[$];
  logic [W-1:0] dump_q[$];

  // Reference model state: whole-word values.
  logic [W-1:0] acc_m;
  logic [W-1:0] op_m;
  logic         carry_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic read_acc(output logic [W-1:0] v);
    v = '0;
    for (int i = 0; i < NB; i++) begin
      bus.rd_sel = SELW'(i);
      #1;
      v[8*i+:8] = bus.dout;
    end
  endtask

  // Monitor: sole driver of rd_sel.
  initial begin
    int           busy_cnt;
    exp_t         e;
    logic [W-1:0] got;
    logic [W-1:0] want;
    busy_cnt   = 0;
    bus.rd_sel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else if (bus.done) begin
        check("busy_len", 64'(busy_cnt), 64'(NB));
        check("busy_in_done", 64'(bus.busy), 64'd0);
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          read_acc(got);
          check("acc", 64'(got), 64'(e.acc));
          check("carry_out", 64'(bus.carry_out), 64'(e.co));
        end
        busy_cnt = 0;
      end else if (bus.busy) begin
        busy_cnt++;
      end else begin
        busy_cnt = 0;
        if (dump_q.size() != 0) begin
          want = dump_q.pop_front();
          read_acc(got);
          check("idle_acc", 64'(got), 64'(want));
        end
      end
    end
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < NB; i++) v[8*i+:8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input logic [W-1:0] v);
    for (int i = 0; i < NB; i++) begin
      bus.din       = v[8*i+:8];
      bus.din_valid = 1'b1;
      tick();
    end
    bus.din_valid = 1'b0;
    op_m = v;
  endtask

  task automatic clear_acc();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    acc_m   = '0;
    op_m    = '0;
    carry_m = 1'b0;
    check("clear_busy", 64'(bus.busy), 64'd0);
    check("clear_carry", 64'(bus.carry_out), 64'd0);
  endtask

  task automatic model_op(input logic sub_b);
    logic [W:0] full;
`ifdef BYTE_ACC_SUB_EN
    if (sub_b) begin
      carry_m = (acc_m >= op_m);
      acc_m   = acc_m - op_m;
    end else begin
      full    = {1'b0, acc_m} + {1'b0, op_m};
      acc_m   = full[W-1:0];
      carry_m = full[W];
    end
`else
    full    = {1'b0, acc_m} + {1'b0, op_m};
    acc_m   = full[W-1:0];
    carry_m = full[W];
    if (sub_b) full = '0;
`endif
    exp_q.push_back('{acc: acc_m, co: carry_m});
  endtask

  // Start one operation; optionally hammer the command inputs while it runs.
  task automatic do_op(input logic sub_b, input logic noise);
    int w;
    bus.sub   = sub_b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    model_op(sub_b);
    check("busy_rise", 64'(bus.busy), 64'd1);
    for (int c = 0; c < NB; c++) begin
      if (noise) begin
        bus.din       = 8'($urandom_range(0, 255));
        bus.din_valid = 1'b1;
        bus.start     = 1'b1;
        bus.clear     = 1'($urandom_range(0, 1));
        bus.sub       = 1'($urandom_range(0, 1));
      end
      tick();
    end
    bus.din_valid = 1'b0;
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.sub       = 1'b0;
    w = 0;
    while (bus.busy && w < 50) begin
      tick();
      w++;
    end
    check("busy_fall", 64'(bus.busy), 64'd0);
  endtask

  task automatic idle_check(input logic [W-1:0] v);
    int w;
    dump_q.push_back(v);
    w = 0;
    while (dump_q.size() != 0 && w < 20) begin
      tick();
      w++;
    end
    check("idle_served", 64'(dump_q.size()), 64'd0);
  endtask

  initial begin
    int w;
    rst_n         = 1'b0;
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.sub       = 1'b0;
    acc_m         = '0;
    op_m          = '0;
    carry_m       = 1'b0;
    #2;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_carry", 64'(bus.carry_out), 64'd0);
    check("rst_dout", 64'(bus.dout), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_check('0);

    // 0xFF + 0x01 ripples a carry into byte 1.
    load_op(32'h0000_00FF);
    do_op(1'b0, 1'b0);
    load_op(32'h0000_0001);
    do_op(1'b0, 1'b0);

    // Full-width wrap sets carry_out.
    clear_acc();
    load_op(32'hFFFF_FFFF);
    do_op(1'b0, 1'b0);
    load_op(32'h0000_0001);
    do_op(1'b0, 1'b0);
    idle_check('0);

    // Commands during RUN are ignored; second start reuses the kept operand.
    load_op(rand_word());
    do_op(1'b0, 1'b1);
    do_op(1'b0, 1'b0);

    // clear wins over start.
    bus.clear = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    acc_m   = '0;
    op_m    = '0;
    carry_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("clr_start_busy", 64'(bus.busy), 64'd0);
      tick();
    end
    check("clr_start_carry", 64'(bus.carry_out), 64'd0);
    idle_check('0);

    // Asynchronous reset in the second RUN cycle.
    load_op(32'h0102_0304);
    do_op(1'b0, 1'b0);
    load_op(32'h0101_0101);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_carry", 64'(bus.carry_out), 64'd0);
    check("mid_rst_dout", 64'(bus.dout), 64'd0);
    acc_m   = '0;
    op_m    = '0;
    carry_m = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (NB + 2) tick();
    idle_check('0);

`ifdef BYTE_ACC_SUB_EN
    clear_acc();
    load_op(32'd5);
    do_op(1'b0, 1'b0);
    load_op(32'd7);
    do_op(1'b1, 1'b0);
    clear_acc();
    load_op(32'd7);
    do_op(1'b0, 1'b0);
    load_op(32'd5);
    do_op(1'b1, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) clear_acc();
      if (r < 7) load_op(rand_word());
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (r == 9) idle_check(acc_m);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      tick();
      w++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
